// File: rtl/post_pkg.sv
// rtl/post_pkg.sv - post_ctrl state encoding and parameter-word field offsets
package post_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MAC = 3'd1,
        ST_FETCH    = 3'd2,
        ST_LOAD     = 3'd3,
        ST_STREAM   = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam int K_LSB    = 0;
    localparam int B_LSB    = 16;
    localparam int BIAS_LSB = 32;
    localparam int FIELD_W  = 16;

endpackage

// File: rtl/wrap_cnt.sv
// rtl/wrap_cnt.sv - enable-driven counter that returns to zero after reaching max
module wrap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q, count_d;

    // wrap is only meaningful in a cycle where the counter advances
    assign wrap  = en && (count_q == max);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/post_ctrl.sv
// rtl/post_ctrl.sv - sequences per-channel parameter fetch and row beats for each MAC tile
module post_ctrl
    import post_pkg::*;
#(
    parameter int POX       = 3,
    parameter int POY       = 3,
    parameter int CHANNEL_N = 2,
    parameter int ADDR_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  num_tiles,
    input  logic [ADDR_W-1:0]            ch_base,
    input  logic                         mac_output_valid,
    output logic                         param_rd,
    output logic [ADDR_W-1:0]            param_addr,
    input  logic [POX*16+31:0]           param_rdata,
    output logic [15:0]                  K,
    output logic [15:0]                  B,
    output logic [POX*16-1:0]            bias,
    output logic [$clog2(CHANNEL_N)-1:0] mux_sel,
    output logic [$clog2(POY)-1:0]       row_sel,
    output logic                         beat_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam int MUX_W = $clog2(CHANNEL_N);
    localparam int ROW_W = $clog2(POY);
    localparam logic [MUX_W-1:0] CH_MAX  = MUX_W'(CHANNEL_N - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(POY - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ch_base_q, ch_base_d;
    logic [15:0]         last_tile_q, last_tile_d;
    logic                overrun_q, overrun_d;
    logic [15:0]         k_q, k_d, b_q, b_d;
    logic [POX*16-1:0]   bias_q, bias_d;

    logic                start_acc, accept;
    logic                row_wrap, ch_en, ch_wrap, tile_en, tile_wrap;
    logic [15:0]         tile_idx_unused;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign accept    = (state_q == ST_STREAM) && out_ready;
    assign ch_en     = accept && row_wrap;
    assign tile_en   = ch_en && ch_wrap;

    wrap_cnt #(.W(ROW_W)) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (accept),
        .max   (ROW_MAX),
        .count (row_sel),
        .wrap  (row_wrap)
    );

    wrap_cnt #(.W(MUX_W)) u_ch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (ch_en),
        .max   (CH_MAX),
        .count (mux_sel),
        .wrap  (ch_wrap)
    );

    wrap_cnt #(.W(16)) u_tile_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (tile_en),
        .max   (last_tile_q),
        .count (tile_idx_unused),
        .wrap  (tile_wrap)
    );

    always_comb begin
        state_d     = state_q;
        ch_base_d   = ch_base_q;
        last_tile_d = last_tile_q;
        overrun_d   = overrun_q;
        k_d         = k_q;
        b_d         = b_q;
        bias_d      = bias_q;

        if (start_acc) begin
            ch_base_d   = ch_base;
            last_tile_d = (num_tiles == 16'd0) ? 16'd0 : num_tiles - 16'd1;
            overrun_d   = 1'b0;
        end
        // a tile announced while not waiting for one is dropped and flagged
        if (mac_output_valid && (state_q != ST_WAIT_MAC)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE:     if (start) state_d = ST_WAIT_MAC;
            ST_WAIT_MAC: if (mac_output_valid) state_d = ST_FETCH;
            ST_FETCH:    state_d = ST_LOAD;
            ST_LOAD: begin
                k_d     = param_rdata[K_LSB +: FIELD_W];
                b_d     = param_rdata[B_LSB +: FIELD_W];
                bias_d  = param_rdata[BIAS_LSB +: POX*16];
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (ch_en) begin
                    if (!ch_wrap) begin
                        state_d = ST_FETCH;
                    end else if (tile_wrap) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_MAC;
                    end
                end
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ch_base_q   <= '0;
            last_tile_q <= '0;
            overrun_q   <= 1'b0;
            k_q         <= '0;
            b_q         <= '0;
            bias_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_base_q   <= ch_base_d;
            last_tile_q <= last_tile_d;
            overrun_q   <= overrun_d;
            k_q         <= k_d;
            b_q         <= b_d;
            bias_q      <= bias_d;
        end
    end

    assign param_rd   = (state_q == ST_FETCH);
    assign param_addr = param_rd ? ch_base_q + ADDR_W'(mux_sel) : '0;
    assign beat_valid = (state_q == ST_STREAM);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign overrun    = overrun_q;
    assign K          = k_q;
    assign B          = b_q;
    assign bias       = bias_q;

endmodule

// File: tb/tb_post_ctrl.sv
// tb/tb_post_ctrl.sv - directed self-checking bench for post_ctrl
module tb_post_ctrl;

    localparam int POX       = 3;
    localparam int POY       = 3;
    localparam int CHANNEL_N = 2;
    localparam int ADDR_W    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_tiles = 16'd0;
    logic [7:0]  ch_base = 8'd0;
    logic        mac_output_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [79:0] param_rdata = 80'd0;

    logic        param_rd;
    logic [7:0]  param_addr;
    logic [15:0] K, B;
    logic [47:0] bias;
    logic        mux_sel;
    logic [1:0]  row_sel;
    logic        beat_valid, busy, done, overrun;

    post_ctrl #(.POX(POX), .POY(POY), .CHANNEL_N(CHANNEL_N), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_tiles        (num_tiles),
        .ch_base          (ch_base),
        .mac_output_valid (mac_output_valid),
        .param_rd         (param_rd),
        .param_addr       (param_addr),
        .param_rdata      (param_rdata),
        .K                (K),
        .B                (B),
        .bias             (bias),
        .mux_sel          (mux_sel),
        .row_sel          (row_sel),
        .beat_valid       (beat_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .done             (done),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pmem(input logic [7:0] a);
        return {8'hB0, a, 8'hB0, a, 8'hB0, a, 8'hBB, a, 8'hCC, a};
    endfunction

    always @(posedge clk) begin
        if (param_rd) param_rdata <= pmem(param_addr);
    end

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) out_ready = ~out_ready;
        else out_ready = 1'b1;
    end

    logic [7:0]   addr_log[$];
    int           beat_cnt = 0;
    int           done_cnt = 0;
    logic [31:0]  seq = 32'd0;
    logic [7:0]   cur_base = 8'd0;
    logic         stall_pend = 1'b0;
    logic [127:0] stall_snap = 128'd0;

    function automatic logic [127:0] snap();
        return 128'({beat_valid, mux_sel, row_sel, K, B, bias});
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({busy, done, overrun, beat_valid, param_rd, param_addr, mux_sel, row_sel, K, B, bias});
    endfunction

    always @(negedge clk) begin
        logic [7:0] a;
        if (param_rd) addr_log.push_back(param_addr);
        if (done) done_cnt++;
        if (stall_pend) check("stall_hold", snap(), stall_snap);
        stall_pend = beat_valid && !out_ready && rst;
        stall_snap = snap();
        if (beat_valid && out_ready) begin
            beat_cnt++;
            seq = {seq[27:0], 1'b0, mux_sel, row_sel};
            a = cur_base + {7'd0, mux_sel};
            check("beat_params", 128'({bias, B, K}), 128'(pmem(a)));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log(input logic [7:0] base);
        addr_log.delete();
        beat_cnt = 0;
        done_cnt = 0;
        seq      = 32'd0;
        cur_base = base;
    endtask

    task automatic do_start(input logic [15:0] tiles, input logic [7:0] base);
        clear_log(base);
        @(posedge clk); #1;
        start = 1'b1; num_tiles = tiles; ch_base = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_mac(input bit meas);
        int n;
        @(posedge clk); #1;
        mac_output_valid = 1'b1;
        @(posedge clk); #1;
        mac_output_valid = 1'b0;
        if (meas) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!beat_valid && n < 10);
            check("first_beat_latency", 128'(n), 128'(3));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("layer_ends", 128'(busy), 128'(0));
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beat_cnt < target && n < 300) begin
            tick();
            n++;
        end
        check("beats_reached", 128'(beat_cnt >= target), 128'(1));
    endtask

    task automatic check_layer(input int nbeats);
        check("beat_count", 128'(beat_cnt), 128'(nbeats));
        check("beat_seq", 128'(seq[23:0]), 128'(24'h012456));
        check("done_pulses", 128'(done_cnt), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_zero", all_outs(), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // single tile, two channel reads, full beat order
        do_start(16'd1, 8'h10);
        pulse_mac(1'b1);
        wait_idle();
        check_layer(6);
        check("t1_reads", 128'(addr_log.size()), 128'(2));
        if (addr_log.size() == 2) begin
            check("t1_addr0", 128'(addr_log[0]), 128'(8'h10));
            check("t1_addr1", 128'(addr_log[1]), 128'(8'h11));
        end
        check("t1_overrun", 128'(overrun), 128'(0));

        // stalls every other cycle
        ready_mode = 1;
        do_start(16'd1, 8'h20);
        pulse_mac(1'b1);
        wait_idle();
        check_layer(6);
        ready_mode = 0;

        // zero tiles acts as one
        do_start(16'd0, 8'h10);
        pulse_mac(1'b1);
        wait_idle();
        check_layer(6);
        check("t3_reads", 128'(addr_log.size()), 128'(2));

        // three tiles with a wait between each
        do_start(16'd3, 8'h60);
        for (int t = 0; t < 3; t++) begin
            pulse_mac(1'b1);
            wait_beats(6 * (t + 1));
            if (t < 2) begin
                tick();
                tick();
                check("between_tiles", 128'({busy, beat_valid}), 128'(2'b10));
                check("no_early_done", 128'(done_cnt), 128'(0));
            end
        end
        wait_idle();
        check("t4_beats", 128'(beat_cnt), 128'(18));
        check("t4_seq", 128'(seq[23:0]), 128'(24'h012456));
        check("t4_done", 128'(done_cnt), 128'(1));
        check("t4_reads", 128'(addr_log.size()), 128'(6));

        // stray mac pulse mid-stream
        do_start(16'd1, 8'h30);
        pulse_mac(1'b1);
        wait_beats(2);
        pulse_mac(1'b0);
        wait_idle();
        check_layer(6);
        check("t5_overrun_set", 128'(overrun), 128'(1));

        // start and mac in the same idle cycle
        clear_log(8'h40);
        @(posedge clk); #1;
        start = 1'b1; mac_output_valid = 1'b1; num_tiles = 16'd1; ch_base = 8'h40;
        @(posedge clk); #1;
        start = 1'b0; mac_output_valid = 1'b0;
        tick();
        check("same_cycle_overrun", 128'({overrun, busy}), 128'(2'b11));
        repeat (3) tick();
        check("same_cycle_no_fetch", 128'(addr_log.size()), 128'(0));
        check("same_cycle_wait", 128'(beat_valid), 128'(0));
        pulse_mac(1'b1);
        wait_idle();
        check_layer(6);

        // address wrap at the top of the parameter space
        do_start(16'd1, 8'hFF);
        tick();
        check("start_clears_overrun", 128'(overrun), 128'(0));
        pulse_mac(1'b1);
        wait_idle();
        check_layer(6);
        check("t6_reads", 128'(addr_log.size()), 128'(2));
        if (addr_log.size() == 2) begin
            check("t6_addr0", 128'(addr_log[0]), 128'(8'hFF));
            check("t6_addr1", 128'(addr_log[1]), 128'(8'h00));
        end

        // asynchronous reset mid-stream
        do_start(16'd1, 8'h50);
        pulse_mac(1'b1);
        wait_beats(2);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("reset_async", all_outs(), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) tick();
        check("post_reset_idle", 128'({busy, beat_valid, done}), 128'(0));
        check("post_reset_no_done", 128'(done_cnt), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/post_ctrl.md
POST_CTRL -- requirements
Module: post_ctrl

Interface
REQ-001 SHALL have parameter POX, 3, output pixels per row beat (each 16-bit Q-format).
REQ-002 SHALL have parameter POY, 3, rows per channel tile.
REQ-003 SHALL have parameter CHANNEL_N, 2, channels per MAC tile.
REQ-004 SHALL have parameter ADDR_W, 8, parameter-memory address width.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse; begins a layer.
REQ-008 SHALL have port num_tiles  input  16  tiles in the layer; sampled on start; 0 treated as 1.
REQ-009 SHALL have port ch_base  input  ADDR_W  parameter address of channel 0; sampled on start.
REQ-010 SHALL have port mac_output_valid  input  1  one-cycle pulse: a CHANNEL_N*POY*POX tile is ready.
REQ-011 SHALL have port param_rd  output  1  parameter-memory read strobe.
REQ-012 SHALL have port param_addr  output  ADDR_W  read address.
REQ-013 SHALL have port param_rdata  input  POX*16+32  {bias[POX*16], B[16], K[16]}, valid the cycle after param_rd.
REQ-014 SHALL have ports K, B (output 16 each) and bias (output POX*16): held BN/conv parameters for the current channel.
REQ-015 SHALL have port mux_sel  output  $clog2(CHANNEL_N)  current channel.
REQ-016 SHALL have port row_sel  output  $clog2(POY)  current row within the channel.
REQ-017 SHALL have port beat_valid  input/output  output 1  row beat presented to post-processing.
REQ-018 SHALL have port out_ready  input  1  downstream accepts the beat when beat_valid and out_ready are both high.
REQ-019 SHALL have ports busy, done, overrun (output 1 each): layer active, one-cycle completion pulse, sticky error.

Function
REQ-020 SHALL implement states IDLE, WAIT_MAC, FETCH, LOAD, STREAM, DONE.
REQ-021 IDLE->WAIT_MAC on start; SHALL latch num_tiles and ch_base, clear tile/channel/row counters and overrun.
REQ-022 WAIT_MAC->FETCH on mac_output_valid.
REQ-023 FETCH SHALL last one cycle, with param_rd=1 and param_addr=ch_base+mux_sel (modulo 2^ADDR_W); the next state is LOAD.
REQ-024 LOAD SHALL capture param_rdata into K/B/bias at the end of that cycle; the next state is STREAM.
REQ-025 First beat_valid SHALL be exactly 3 cycles after the cycle mac_output_valid is sampled.
REQ-026 STREAM SHALL hold beat_valid=1; row_sel SHALL increment only on accept; beat_valid, mux_sel, row_sel, K, B and bias SHALL be stable while out_ready=0.
REQ-027 On accept of row POY-1: if mux_sel<CHANNEL_N-1, SHALL increment mux_sel, reset row_sel and go to FETCH.
REQ-028 On that accept with mux_sel=CHANNEL_N-1: if the tile is the last one, SHALL go to DONE; otherwise SHALL increment the tile count, reset mux_sel/row_sel and go to WAIT_MAC.
REQ-029 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 mac_output_valid outside WAIT_MAC SHALL be ignored for sequencing and SHALL set overrun, which stays set until the next accepted start.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 start and mac_output_valid in the same IDLE cycle: start SHALL be taken and the mac pulse SHALL set overrun.
REQ-034 param_rd SHALL be 0 in every state except FETCH.

Reset
REQ-035 On rst=0, state SHALL be IDLE immediately, without waiting for clk.
REQ-036 On rst=0, all outputs and registers SHALL be 0, including K, B, bias, mux_sel, row_sel and overrun.
REQ-037 A reset during STREAM SHALL abort the layer with no done pulse.

Structure
REQ-038 Package post_pkg SHALL hold the state encoding and the param_rdata field offsets (K_LSB=0, B_LSB=16, BIAS_LSB=32).
REQ-039 The row/channel/tile counters SHALL be one reusable sub-module, wrap_cnt (enable, max, count, wrap flag), instantiated three times.

Verification
REQ-040 With CHANNEL_N=2, POY=3, num_tiles=1, ch_base=0x10, out_ready=1: reads at 0x10 then 0x11, 6 beats with (mux_sel,row_sel) = 00,01,02,10,11,12, then done.
REQ-041 With out_ready toggling 1,0 every cycle: 6 accepted beats, and outputs held while stalled.
REQ-042 num_tiles=0 SHALL behave identically to num_tiles=1; with num_tiles=3, busy returns to WAIT_MAC between tiles and done pulses once after 18 beats.
REQ-043 A mac_output_valid pulse during STREAM SHALL raise overrun with the beat sequence unchanged; a following start SHALL clear overrun.
REQ-044 ch_base=0xFF with CHANNEL_N=2: param_addr SHALL be 0xFF then 0x00.
REQ-045 rst=0 asserted mid-STREAM: all outputs 0 asynchronously; after release, the block idles until start.
